// File: rtl/axi4_lite_req_arbiter_pkg.sv
// Shared response codes and arbiter FSM state encoding for the AXI4-Lite
// request arbiter.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/axi4_lite_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping around, returned as one-hot, index and valid.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  int            k;
  logic [IW-1:0] k_idx;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = 0;
    k_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      k_idx = IW'(k);
      if (!valid && req[k_idx]) begin
        valid         = 1'b1;
        idx           = k_idx;
        onehot[k_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Shares one AXI4-Lite master among NUM_REQ requesters: round-robin grant,
// one transaction in flight, completion by snooping R/B, watchdog error.
module axi4_lite_req_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS    = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDRESS-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [1:0]                    rsp_resp,
  output logic                          timeout_err,
  output logic                          read_s,
  output logic                          write_s,
  output logic [ADDRESS-1:0]            address,
  output logic [DATA_WIDTH-1:0]         W_data,
  input  logic                          mon_rvalid,
  input  logic                          mon_rready,
  input  logic [DATA_WIDTH-1:0]         mon_rdata,
  input  logic [1:0]                    mon_rresp,
  input  logic                          mon_bvalid,
  input  logic                          mon_bready,
  input  logic [1:0]                    mon_bresp
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  arb_state_t         state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic               we_q;
  logic [WD_W-1:0]    wd;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic               hs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  // Only the handshake matching the latched op type counts as completion.
  assign hs = we_q ? (mon_bvalid & mon_bready) : (mon_rvalid & mon_rready);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      we_q        <= 1'b0;
      wd          <= '0;
      gnt         <= '0;
      done        <= '0;
      rsp_data    <= '0;
      rsp_resp    <= RESP_OKAY;
      timeout_err <= 1'b0;
      read_s      <= 1'b0;
      write_s     <= 1'b0;
      address     <= '0;
      W_data      <= '0;
    end else begin
      read_s      <= 1'b0;
      write_s     <= 1'b0;
      done        <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner   <= pick_idx;
            we_q    <= req_we[pick_idx];
            address <= req_addr[int'(pick_idx)*ADDRESS +: ADDRESS];
            W_data  <= req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            gnt     <= pick_onehot;
            read_s  <= ~req_we[pick_idx];
            write_s <= req_we[pick_idx];
            wd      <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          // A real handshake takes priority over a watchdog expiry in the same cycle.
          if (hs) begin
            rsp_data <= we_q ? '0 : mon_rdata;
            rsp_resp <= we_q ? mon_bresp : mon_rresp;
            done     <= gnt;
            state    <= RESP;
          end else if (state == WAIT && wd == WD_MAX) begin
            rsp_data    <= '0;
            rsp_resp    <= RESP_SLVERR;
            timeout_err <= 1'b1;
            done        <= gnt;
            state       <= RESP;
          end else begin
            if (state == WAIT) wd <= wd + 1'b1;
            state <= WAIT;
          end
        end
        RESP: begin
          gnt   <= '0;
          ptr   <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
